// File: rtl/dcb_down_counter.sv
// Loadable down counter with a clock-division prescaler. Counts down once per
// prescaler tick, pulses dcb_zero on reaching 0, then stops or reloads.
module dcb_down_counter #(
  parameter logic [26:0] CLK_DIVISION = 27'd100000000,
  parameter int          WIDTH        = 4
) (
  input  logic             dcb_clk,
  input  logic             dcb_rst,
  input  logic             dcb_en,
  input  logic             dcb_load,
  input  logic [WIDTH-1:0] dcb_load_val,
  input  logic             dcb_auto_reload,
  output logic [WIDTH-1:0] dcb_out,
  output logic             dcb_tick,
  output logic             dcb_zero,
  output logic             dcb_busy
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  state_t           state, state_nx;
  logic [26:0]      presc, presc_nx;
  logic [WIDTH-1:0] cnt, cnt_nx;
  logic [WIDTH-1:0] reload, reload_nx;
  logic             tick, tick_nx;
  logic             zero, zero_nx;
  logic             wrap;

  assign wrap = (presc == CLK_DIVISION - 27'd1);

  always_ff @(posedge dcb_clk) begin
    if (dcb_rst) begin
      state  <= IDLE;
      presc  <= '0;
      cnt    <= '0;
      reload <= '0;
      tick   <= 1'b0;
      zero   <= 1'b0;
    end else begin
      state  <= state_nx;
      presc  <= presc_nx;
      cnt    <= cnt_nx;
      reload <= reload_nx;
      tick   <= tick_nx;
      zero   <= zero_nx;
    end
  end

  always_comb begin
    state_nx  = state;
    presc_nx  = presc;
    cnt_nx    = cnt;
    reload_nx = reload;
    tick_nx   = 1'b0;
    zero_nx   = 1'b0;
    if (dcb_load) begin
      // A load restarts the countdown from scratch and masks any coincident tick.
      reload_nx = dcb_load_val;
      cnt_nx    = dcb_load_val;
      presc_nx  = '0;
      state_nx  = (dcb_load_val != '0) ? RUN : IDLE;
    end else if (state == RUN && dcb_en) begin
      if (wrap) begin
        presc_nx = '0;
        tick_nx  = 1'b1;
        if (cnt == '0) begin
          cnt_nx = reload;
        end else begin
          cnt_nx = cnt - ONE;
          if (cnt == ONE) begin
            zero_nx = 1'b1;
            if (!dcb_auto_reload) state_nx = DONE;
          end
        end
      end else begin
        presc_nx = presc + 27'd1;
      end
    end
  end

  assign dcb_out  = cnt;
  assign dcb_tick = tick;
  assign dcb_zero = zero;
  assign dcb_busy = (state == RUN);

endmodule
